alarm_trigger: RTL and testbench
================================

Name: alarm_trigger

Overview:
- Consumer side of the alarm-time register.
- Compares the running watch time against the stored alarm hour/minute and raises the ring output at the top of the matching minute.
- Manages ring timeout, user stop and snooze via a small state machine.
- Sits between the alarm/time registers and the buzzer/LED driver in the digital watch top level.

Parameters:
RING_SEC, 60, seconds the alarm rings before auto-off (1..65535)
SNOOZE_SEC, 300, seconds spent in snooze before ringing again (1..65535)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses act as stop (1..15)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
sec_tick  input  1  one-clock pulse once per second from the watch timebase
alarm_en  input  1  alarm armed (level)
stop  input  1  one-clock pulse, user stop
snooze  input  1  one-clock pulse, user snooze
time_second  input  8  current second, BCD (high nibble tens)
time_minute  input  8  current minute, BCD
time_hour  input  8  current hour, BCD 00..23
alarm_minute  input  8  alarm minute, BCD
alarm_hour  input  8  alarm hour, BCD
ring  output  1  alarm sounding
beep  output  1  gated tone enable, 1 s on / 1 s off while ringing
snoozing  output  1  in snooze wait
snooze_left  output  4  remaining snoozes for current event

Behaviour:
- One clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values:
  - state=IDLE, ring=0, beep=0, snoozing=0, snooze_left=MAX_SNOOZE.
  - Counters are 0.
  - match_d=1, so no spurious ring if time already equals alarm at reset release.
- match (combinational) = alarm_en & (time_hour==alarm_hour) & (time_minute==alarm_minute) & (time_second==8'h00).
- Plain byte equality; no BCD validation.
- trigger = match & ~match_d; match_d registers match every cycle.
- States: IDLE, RING, SNOOZE. ring=1 only in RING; snoozing=1 only in SNOOZE.
- IDLE: on trigger, go to RING next edge (ring high one clock after match first true), ring_cnt=0, phase=0, snooze_left=MAX_SNOOZE.
- RING:
  - ring_cnt increments on each sec_tick; phase toggles on each sec_tick.
  - When sec_tick and ring_cnt==RING_SEC-1, go to IDLE.
  - stop: go to IDLE.
  - snooze with snooze_left>0: go to SNOOZE, snz_cnt=0, snooze_left decrements.
  - snooze with snooze_left==0: same as stop.
- SNOOZE:
  - snz_cnt increments on sec_tick.
  - When sec_tick and snz_cnt==SNOOZE_SEC-1, go to RING with ring_cnt=0, phase=0.
  - stop: go to IDLE. snooze is ignored.
- Priority per cycle: reset > alarm_en==0 (any state goes to IDLE) > stop > snooze > timeout > trigger.
- Simultaneous stop+snooze: stop wins.
- trigger while in RING or SNOOZE is ignored.
- beep = ring & ~phase, registered with ring, so it is high for the first second of every ring entry.
- Counters are 16-bit, compared exactly; they are cleared on every state entry and never wrap in normal use.
- Alarm edited mid-ring: no effect on the current event; a new trigger requires a fresh rising edge of match from IDLE.
- Alarm set to current minute after second 00: no ring until next day.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: snooze behaviour as above.
- Undefined:
  - snooze input ignored, SNOOZE state unreachable.
  - snoozing tied 0, snooze_left tied 0.
  - MAX_SNOOZE and SNOOZE_SEC unused.
  - Only stop, alarm_en low and timeout end ringing.

Test Plan:
All scenarios use the bench override RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2, with sec_tick every 10 clocks.
- Basic match: alarm 07:30, alarm_en=1, time steps 07:29:59 -> 07:30:00 -> ring=1 exactly 1 clock after time_second becomes 00. beep=1 for ticks 0..0, then 0, then 1. ring=0 after 4th sec_tick.
- Stop: during RING, pulse stop -> ring=0 next edge. Holding time at 07:30:00 does not re-trigger. Time 07:30:01 then 07:30:00 (rewind) re-triggers.
- Snooze (ALARM_SNOOZE_EN):
  - snooze in RING -> snoozing=1, snooze_left=1, ring=0.
  - After 3 sec_ticks, ring=1 again with beep restarting high.
  - Second snooze -> snooze_left=0.
  - Third snooze press in RING -> IDLE.
- Priority: stop and snooze in the same clock during RING -> IDLE, snooze_left unchanged. Drop alarm_en during SNOOZE -> IDLE, snoozing=0 next edge.
- Reset: assert reset mid-RING -> all outputs at reset values next edge. Release with time==alarm at second 00 -> no ring.
- Build without ALARM_SNOOZE_EN: snooze pulses in RING -> no state change. Ring ends only on the 4th sec_tick or stop.

Source files
------------

// File: rtl/alarm_trigger.sv
// Alarm comparator and ring/snooze state machine: ring rises one clock after the matching hh:mm:00 appears.
// Optional snooze support is compiled in with ALARM_SNOOZE_EN; without it, only stop, alarm_en low or timeout end a ring.
module alarm_trigger #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  input  logic [7:0] time_second,
  input  logic [7:0] time_minute,
  input  logic [7:0] time_hour,
  input  logic [7:0] alarm_minute,
  input  logic [7:0] alarm_hour,
  output logic       ring,
  output logic       beep,
  output logic       snoozing,
  output logic [3:0] snooze_left
);

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

  state_t      state, state_n;
  logic [15:0] ring_cnt, ring_cnt_n;
  logic        phase, phase_n;
  logic        match, match_d, trigger;
`ifdef ALARM_SNOOZE_EN
  logic [15:0] snz_cnt, snz_cnt_n;
  logic [3:0]  left, left_n;
`endif

  assign match   = alarm_en & (time_hour == alarm_hour) & (time_minute == alarm_minute)
                 & (time_second == 8'h00);
  assign trigger = match & ~match_d;

  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    phase_n    = phase;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_n  = snz_cnt;
    left_n     = left;
`endif
    if (!alarm_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_n    = RING;
            ring_cnt_n = '0;
            phase_n    = 1'b0;
`ifdef ALARM_SNOOZE_EN
            left_n     = 4'(MAX_SNOOZE);
`endif
          end
        end
        RING: begin
          if (stop) begin
            state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            // Snooze with none left behaves as stop.
            if (left != 4'd0) begin
              state_n   = SNOOZE;
              snz_cnt_n = '0;
              left_n    = left - 4'd1;
            end else begin
              state_n = IDLE;
            end
`endif
          end else if (sec_tick) begin
            if (ring_cnt == 16'(RING_SEC - 1)) begin
              state_n = IDLE;
            end else begin
              ring_cnt_n = ring_cnt + 16'd1;
              phase_n    = ~phase;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) begin
            state_n = IDLE;
          end else if (sec_tick) begin
            if (snz_cnt == 16'(SNOOZE_SEC - 1)) begin
              state_n    = RING;
              ring_cnt_n = '0;
              phase_n    = 1'b0;
            end else begin
              snz_cnt_n = snz_cnt + 16'd1;
            end
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
    if (state_n == IDLE) begin
      ring_cnt_n = '0;
      phase_n    = 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_n  = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      phase    <= 1'b0;
      // Held high so a time already equal to the alarm at release does not ring.
      match_d  <= 1'b1;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
      left     <= 4'(MAX_SNOOZE);
`endif
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
      phase    <= phase_n;
      match_d  <= match;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= snz_cnt_n;
      left     <= left_n;
`endif
    end
  end

  assign ring = (state == RING);
  assign beep = ring & ~phase;

`ifdef ALARM_SNOOZE_EN
  assign snoozing    = (state == SNOOZE);
  assign snooze_left = left;
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze, 16'(SNOOZE_SEC), 4'(MAX_SNOOZE)};
  assign snoozing      = 1'b0;
  assign snooze_left   = 4'd0;
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2 and sec_tick every 10 clocks.
module tb_alarm_trigger;

  logic       clock = 1'b0;
  logic       reset, sec_tick, alarm_en, stop, snooze;
  logic [7:0] time_second, time_minute, time_hour, alarm_minute, alarm_hour;
  logic       ring, beep, snoozing;
  logic [3:0] snooze_left;

  int tests = 0;
  int fails = 0;

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0] SL_MAX = 4'd2;
`else
  localparam logic [3:0] SL_MAX = 4'd0;
`endif

  always #5 clock = ~clock;

  alarm_trigger #(.RING_SEC(4), .SNOOZE_SEC(3), .MAX_SNOOZE(2)) dut (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .alarm_en(alarm_en),
    .stop(stop), .snooze(snooze), .time_second(time_second), .time_minute(time_minute),
    .time_hour(time_hour), .alarm_minute(alarm_minute), .alarm_hour(alarm_hour),
    .ring(ring), .beep(beep), .snoozing(snoozing), .snooze_left(snooze_left)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One watch second: nine quiet clocks then a tick clock.
  task automatic sec();
    steps(9);
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  // Step time 07:30:01 -> 07:30:00 to create a fresh match edge.
  task automatic retrig();
    time_second = 8'h01;
    step();
    time_second = 8'h00;
    step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; sec_tick = 1'b0; alarm_en = 1'b1; stop = 1'b0; snooze = 1'b0;
    time_hour = 8'h07; time_minute = 8'h29; time_second = 8'h59;
    alarm_hour = 8'h07; alarm_minute = 8'h30;
    steps(2);
    chk("rst_ring", 16'(ring), 16'h0);
    chk("rst_beep", 16'(beep), 16'h0);
    chk("rst_snoozing", 16'(snoozing), 16'h0);
    chk("rst_left", 16'(snooze_left), 16'(SL_MAX));
    reset = 1'b0;
    step();
    chk("idle_ring", 16'(ring), 16'h0);

    // Basic match and timeout
    time_minute = 8'h30; time_second = 8'h00;
    #1;
    chk("pre_edge_ring", 16'(ring), 16'h0);
    step();
    chk("match_ring", 16'(ring), 16'h1);
    chk("match_beep", 16'(beep), 16'h1);
    chk("match_left", 16'(snooze_left), 16'(SL_MAX));
    sec();
    chk("t1_ring", 16'(ring), 16'h1);
    chk("t1_beep", 16'(beep), 16'h0);
    sec();
    chk("t2_beep", 16'(beep), 16'h1);
    sec();
    chk("t3_ring", 16'(ring), 16'h1);
    chk("t3_beep", 16'(beep), 16'h0);
    sec();
    chk("t4_ring", 16'(ring), 16'h0);
    chk("t4_beep", 16'(beep), 16'h0);
    steps(5);
    chk("hold_no_retrig", 16'(ring), 16'h0);

    // Stop and rewind
    retrig();
    chk("rewind_ring", 16'(ring), 16'h1);
    sec();
    chk("stop_pre_beep", 16'(beep), 16'h0);
    pulse_stop();
    chk("stop_ring", 16'(ring), 16'h0);
    chk("stop_beep", 16'(beep), 16'h0);
    steps(5);
    chk("stop_hold", 16'(ring), 16'h0);
    retrig();
    chk("rewind2_ring", 16'(ring), 16'h1);
    chk("rewind2_beep", 16'(beep), 16'h1);

    // Alarm edits during a ring do not disturb it or re-arm it
    alarm_minute = 8'h45;
    step();
    chk("edit_ring", 16'(ring), 16'h1);
    alarm_minute = 8'h30;
    step();
    chk("edit_back_ring", 16'(ring), 16'h1);
    pulse_stop();
    chk("edit_stop_ring", 16'(ring), 16'h0);
    steps(3);
    chk("edit_no_retrig", 16'(ring), 16'h0);

`ifdef ALARM_SNOOZE_EN
    retrig();
    chk("snz_new_left", 16'(snooze_left), 16'h2);
    pulse_snooze();
    chk("snz1_ring", 16'(ring), 16'h0);
    chk("snz1_snoozing", 16'(snoozing), 16'h1);
    chk("snz1_left", 16'(snooze_left), 16'h1);
    sec();
    sec();
    chk("snz1_wait_snoozing", 16'(snoozing), 16'h1);
    chk("snz1_wait_ring", 16'(ring), 16'h0);
    sec();
    chk("snz1_back_ring", 16'(ring), 16'h1);
    chk("snz1_back_beep", 16'(beep), 16'h1);
    chk("snz1_back_snoozing", 16'(snoozing), 16'h0);
    sec();
    chk("snz1_phase_beep", 16'(beep), 16'h0);
    pulse_snooze();
    chk("snz2_left", 16'(snooze_left), 16'h0);
    chk("snz2_snoozing", 16'(snoozing), 16'h1);
    sec(); sec(); sec();
    chk("snz2_back_ring", 16'(ring), 16'h1);
    chk("snz2_back_beep", 16'(beep), 16'h1);
    pulse_snooze();
    chk("snz3_ring", 16'(ring), 16'h0);
    chk("snz3_snoozing", 16'(snoozing), 16'h0);
    chk("snz3_left", 16'(snooze_left), 16'h0);

    // Stop beats snooze; alarm_en low leaves snooze
    retrig();
    chk("prio_left_reload", 16'(snooze_left), 16'h2);
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    chk("prio_ring", 16'(ring), 16'h0);
    chk("prio_snoozing", 16'(snoozing), 16'h0);
    chk("prio_left", 16'(snooze_left), 16'h2);
    retrig();
    pulse_snooze();
    chk("en_pre_snoozing", 16'(snoozing), 16'h1);
    alarm_en = 1'b0;
    step();
    chk("en_off_snoozing", 16'(snoozing), 16'h0);
    chk("en_off_ring", 16'(ring), 16'h0);
`else
    retrig();
    pulse_snooze();
    chk("nosnz_ring", 16'(ring), 16'h1);
    chk("nosnz_beep", 16'(beep), 16'h1);
    chk("nosnz_snoozing", 16'(snoozing), 16'h0);
    chk("nosnz_left", 16'(snooze_left), 16'h0);
    sec();
    chk("nosnz_t1_beep", 16'(beep), 16'h0);
    pulse_snooze();
    chk("nosnz_t1_ring", 16'(ring), 16'h1);
    sec(); sec();
    chk("nosnz_t3_ring", 16'(ring), 16'h1);
    sec();
    chk("nosnz_t4_ring", 16'(ring), 16'h0);
    retrig();
    chk("en_pre_ring", 16'(ring), 16'h1);
    alarm_en = 1'b0;
    step();
    chk("en_off_ring", 16'(ring), 16'h0);
`endif
    time_second = 8'h01;
    alarm_en = 1'b1;
    step();

    // Reset mid-ring, release while time equals alarm at second 00
    retrig();
    chk("rst2_pre_ring", 16'(ring), 16'h1);
    reset = 1'b1;
    step();
    chk("rst2_ring", 16'(ring), 16'h0);
    chk("rst2_beep", 16'(beep), 16'h0);
    chk("rst2_snoozing", 16'(snoozing), 16'h0);
    chk("rst2_left", 16'(snooze_left), 16'(SL_MAX));
    step();
    reset = 1'b0;
    steps(3);
    chk("rst2_release_ring", 16'(ring), 16'h0);

    // Alarm set to the current minute after second 00
    time_minute = 8'h31; time_second = 8'h05; alarm_minute = 8'h31;
    steps(3);
    chk("late_set_ring", 16'(ring), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
